// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetches 16-bit instructions from a synchronous ROM and steps the
// DataSelect/ALU/register-file datapath through SELECT, EXEC and WRITE for each ALU instruction.
module datapath_sequencer #(
    parameter int PC_W  = 8,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PC_W-1:0]  rom_addr,
    input  logic [15:0]      rom_data,
    output logic [2:0]       ra_addr,
    output logic [2:0]       rb_addr,
    output logic             ctl,
    output logic [IMM_W-1:0] romx,
    output logic [3:0]       alu_op,
    input  logic             alu_zero,
    output logic [2:0]       wr_addr,
    output logic             wr_en,
    output logic             busy,
    output logic             done,
    output logic [PC_W-1:0]  pc
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, SELECT, EXEC, WRITE, HALT} state_t;
    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [2:0]       ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
    logic [IMM_W-1:0] romx_q, romx_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             ctl_q, ctl_d, zf_q, zf_d, wr_en_q, wr_en_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [3:0]       op;
    logic [PC_W-1:0]  pc_inc, target;
    logic             is_exec;
    assign op      = rom_data[15:12];
    assign pc_inc  = pc_q + PC_W'(1);
    assign target  = PC_W'(rom_data[7:0]);
    assign is_exec = (op != 4'h0) && (op <= 4'h9);
    // Controls are loaded from the ROM word as DECODE ends so they are already stable throughout SELECT.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        wa_d     = wa_q;
        romx_d   = romx_q;
        alu_op_d = alu_op_q;
        ctl_d    = ctl_q;
        zf_d     = zf_q;
        busy_d   = busy_q;
        wr_en_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                pc_d    = '0;
                busy_d  = 1'b1;
                state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (is_exec) begin
                    ra_d     = (op == 4'h9) ? rom_data[11:9] : rom_data[8:6];
                    rb_d     = rom_data[5:3];
                    wa_d     = rom_data[11:9];
                    ctl_d    = op[3];
                    romx_d   = IMM_W'(rom_data[7:0]);
                    alu_op_d = (op == 4'h8) ? 4'h8 : (op == 4'h9) ? 4'h1 : {1'b0, op[2:0]};
                    state_d  = SELECT;
                end else if (op == 4'hF) begin
                    done_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d    = (op == 4'hA || (op == 4'hB && zf_q)) ? target : pc_inc;
                    state_d = FETCH;
                end
            end
            SELECT: state_d = EXEC;
            EXEC: begin
                wr_en_d = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                zf_d    = alu_zero;
                pc_d    = pc_inc;
                state_d = FETCH;
            end
            HALT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            wa_q     <= '0;
            romx_q   <= '0;
            alu_op_q <= '0;
            ctl_q    <= 1'b0;
            zf_q     <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            wa_q     <= wa_d;
            romx_q   <= romx_d;
            alu_op_q <= alu_op_d;
            ctl_q    <= ctl_d;
            zf_q     <= zf_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign ra_addr  = ra_q;
    assign rb_addr  = rb_q;
    assign wr_addr  = wa_q;
    assign romx     = romx_q;
    assign alu_op   = alu_op_q;
    assign ctl      = ctl_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: an instruction-level model predicts every register write and HALT,
// and a negedge monitor matches them against the sequencer's outputs.
module tb_datapath_sequencer;
    typedef struct {
        logic [2:0] wa, ra, rb;
        logic [3:0] op;
        logic       ctl;
        logic [7:0] imm;
        bit         ck_ra, ck_rb, ck_imm;
        int         cyc;
    } wr_t;
    typedef struct {
        logic [7:0] pc;
        int         cyc;
    } dn_t;

    logic        clk = 1'b0, rst, start = 1'b0, alu_zero = 1'b0;
    logic [7:0]  rom_addr, romx, pc;
    logic [15:0] rom_data = '0;
    logic [2:0]  ra_addr, rb_addr, wr_addr;
    logic [3:0]  alu_op;
    logic        ctl, wr_en, busy, done;
    bit   [15:0] rom [256];
    bit          zbits [64];
    bit          mz = 1'b0, wr_prev = 1'b0;
    int          n_tests = 0, n_fail = 0, cyc = 0, wcnt = 0;
    wr_t         exp_wr[$];
    dn_t         exp_dn[$];

    datapath_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ctl(ctl), .romx(romx), .alu_op(alu_op),
        .alu_zero(alu_zero), .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy), .done(done), .pc(pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // alu_zero for the n-th write of a run is zbits[n]
    initial forever begin
        @(negedge clk);
        if (wr_prev) wcnt++;
        alu_zero = zbits[wcnt % 64];
        wr_prev  = wr_en;
    end

    always @(negedge clk) if (rst === 1'b0) begin : monitor
        wr_t e;
        dn_t d;
        if (wr_en) begin
            chk("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                chk("wr_addr", wr_addr, e.wa);
                chk("alu_op", alu_op, e.op);
                chk("ctl", ctl, e.ctl);
                chk("wr_cycle", cyc, e.cyc);
                if (e.ck_ra) chk("ra_addr", ra_addr, e.ra);
                if (e.ck_rb) chk("rb_addr", rb_addr, e.rb);
                if (e.ck_imm) chk("romx", romx, e.imm);
            end
        end
        if (done) begin
            chk("done_expected", exp_dn.size() > 0, 1);
            if (exp_dn.size() > 0) begin
                d = exp_dn.pop_front();
                chk("halt_pc", pc, d.pc);
                chk("done_cycle", cyc, d.cyc);
            end
        end
    end

    // Instruction-level interpreter: c is the cycle count at which each instruction's FETCH begins
    task automatic model(input int s);
        int p, c, w;
        logic [15:0] ins;
        logic [3:0] op;
        wr_t e;
        dn_t d;
        p = 0; c = s; w = 0;
        for (int n = 0; n < 2000; n++) begin
            ins = rom[p];
            op  = ins[15:12];
            if (op >= 1 && op <= 9) begin
                e.wa = ins[11:9]; e.rb = ins[5:3]; e.imm = ins[7:0];
                e.op = (op == 8) ? 4'h8 : (op == 9) ? 4'h1 : op;
                e.ctl = (op >= 8);
                e.ra = (op == 9) ? ins[11:9] : ins[8:6];
                e.ck_ra = (op != 8); e.ck_rb = (op < 8); e.ck_imm = (op >= 8);
                e.cyc = c + 4;
                exp_wr.push_back(e);
                mz = zbits[w % 64];
                w++;
                p = (p + 1) % 256;
                c += 5;
            end else if (op == 15) begin
                d.pc = 8'(p);
                d.cyc = c + 2;
                exp_dn.push_back(d);
                return;
            end else begin
                p = (op == 10 || (op == 11 && mz)) ? int'(ins[7:0]) : (p + 1) % 256;
                c += 2;
            end
        end
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic set_z(input bit a, input bit b);
        for (int i = 0; i < 64; i++) zbits[i] = 1'b0;
        zbits[0] = a;
        zbits[1] = b;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_ra"}, ra_addr, 0);
        chk({tag, "_rb"}, rb_addr, 0);
        chk({tag, "_wa"}, wr_addr, 0);
        chk({tag, "_ctl"}, ctl, 0);
        chk({tag, "_romx"}, romx, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
    endtask

    task automatic run_prog(input bit pulse);
        int s;
        bit seen;
        wcnt = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        model(s);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            start = pulse && (k == 0);
            seen  = done;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("busy_after_halt", busy, 0);
        chk("done_width", done, 0);
        chk("queues_drained", exp_wr.size() + exp_dn.size(), 0);
        exp_wr.delete();
        exp_dn.delete();
    endtask

    task automatic gen_rand;
        int k, t, o;
        logic [15:0] r;
        clear_rom;
        k = $urandom_range(1, 12);
        for (int i = 0; i < k; i++) begin
            t = $urandom_range(0, 6);
            r = 16'($urandom);
            o = $urandom_range(0, 3);
            case (t)
                0, 1: rom[i] = {4'($urandom_range(1, 7)), r[11:0]};
                2: rom[i] = {4'h8, r[11:0]};
                3: rom[i] = {4'h9, r[11:0]};
                4: rom[i] = {(o == 0) ? 4'h0 : 4'(11 + o), r[11:0]};
                5: rom[i] = {4'hA, 4'h0, 8'($urandom_range(i + 1, k))};
                default: rom[i] = {4'hB, 4'h0, 8'($urandom_range(i + 1, k))};
            endcase
        end
        for (int i = 0; i < 64; i++) zbits[i] = 1'($urandom);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int s;
        bit got;
        rst = 1'b1;
        clear_rom;
        set_z(0, 0);
        repeat (2) @(negedge clk);
        chk_outs("reset");
        rst = 1'b0;
        rom[0] = 16'h8205;
        run_prog(0);
        clear_rom;
        rom[0] = 16'h1650;
        run_prog(0);
        clear_rom;
        rom[0] = 16'h8000; rom[1] = 16'hB010; rom[2] = 16'h8EAA;
        set_z(1, 0);
        run_prog(0);
        set_z(0, 0);
        run_prog(0);
        clear_rom;
        rom[0] = 16'h8433; rom[1] = 16'hB0FF; rom[8'hFF] = 16'h0000;
        set_z(1, 0);
        run_prog(0);
        clear_rom;
        rom[0] = 16'h9A7F; rom[1] = 16'hC000; rom[2] = 16'hA004; rom[4] = 16'h2AC8;
        set_z(0, 1);
        run_prog(1);
        repeat (40) begin
            gen_rand;
            run_prog(1'($urandom));
        end
        clear_rom;
        rom[0] = 16'h8205;
        set_z(1, 1);
        wcnt = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        model(s);
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = wr_en;
        end
        chk("wr_before_reset", got, 1);
        #2 rst = 1'b1;
        #1 chk_outs("rst_in_write");
        exp_wr.delete();
        exp_dn.delete();
        mz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pc", pc, 0);
        clear_rom;
        rom[0] = 16'hB007; rom[1] = 16'h8C00;
        set_z(0, 0);
        run_prog(0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Micro-sequencer that drives the DataSelect/ALU/register-file datapath from a program ROM.
- Fetches 16-bit instruction words, decodes them, and drives register read addresses, the DataSelect `Ctl` select and its `romx` immediate, the ALU opcode and the register-file write enable.
- Owns the program counter and a zero flag; provides a start/busy/done handshake to the surrounding system.
- Every ALU instruction is stepped through the registered operand stage in DataSelect and then written back.

Parameters:
PC_W, 8, width of program counter / ROM address (jump target is imm[PC_W-1:0])
IMM_W, 8, immediate width; equals DataSelect data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin execution at PC=0 (sampled in IDLE only)
rom_addr  out  PC_W  program ROM address (synchronous ROM, 1-cycle read latency)
rom_data  in  16  instruction word, valid the cycle after rom_addr is presented
ra_addr  out  3  register-file read address A (feeds DataSelect Da)
rb_addr  out  3  register-file read address B (feeds DataSelect Db)
ctl  out  1  DataSelect Ctl: 0 = Db, 1 = romx
romx  out  IMM_W  immediate operand to DataSelect
alu_op  out  4  ALU operation code
alu_zero  in  1  ALU result==0, combinational from ALU
wr_addr  out  3  register-file write address
wr_en  out  1  register-file write strobe
busy  out  1  high from accepted start until HALT retires
done  out  1  one-cycle pulse when HALT retires
pc  out  PC_W  current program counter

Behaviour:
- Reset (async, rst=1): state=IDLE; pc, ir, zflag and all outputs = 0.
- Instruction fields:
  - op=[15:12], rd=[11:9], ra=[8:6], rb=[5:3], imm=[7:0].
- Decode:
  - op 0000 NOP: no write.
  - op 0001-0111 reg ALU: alu_op={0,op[2:0]}, ra_addr=ra, rb_addr=rb, ctl=0, wr_addr=rd.
  - op 1000 LDI: alu_op=4'h8 (PASSB), ctl=1, romx=imm, wr_addr=rd.
  - op 1001 ADDI: alu_op=4'h1, ra_addr=rd, ctl=1, romx=imm, wr_addr=rd.
  - op 1010 JMP: pc<=imm[PC_W-1:0].
  - op 1011 JZ: if zflag, pc<=imm[PC_W-1:0]; else pc<=pc+1.
  - op 1111 HALT.
  - op 1100-1110: treated as NOP.
- States: IDLE, FETCH, DECODE, SELECT, EXEC, WRITE, HALT.
- IDLE: busy=0. On start=1: pc<=0, busy<=1, ->FETCH. start is ignored in every other state.
- FETCH: rom_addr=pc for one cycle, ->DECODE.
- DECODE: ir<=rom_data.
  - ALU/LDI/ADDI: ->SELECT.
  - JMP/JZ/NOP: update pc, ->FETCH.
  - HALT: ->HALT.
- SELECT: ra_addr/rb_addr/ctl/romx/alu_op/wr_addr driven from ir. DataSelect captures operands at the edge ending SELECT. ->EXEC.
- EXEC: controls held; ALU settles. ->WRITE.
- WRITE: wr_en=1 for exactly this cycle; zflag<=alu_zero at the edge ending WRITE; pc<=pc+1; ->FETCH.
- HALT: done=1 for one cycle, busy<=0, ->IDLE. pc retains the HALT address.
- Control outputs are registered and hold their last value until the next SELECT. wr_en and done are 0 outside WRITE/HALT.
- Cycle counts from FETCH entry to next FETCH entry:
  - ALU/LDI/ADDI = 5.
  - NOP/JMP/JZ = 2.
  - Start to first FETCH = 1 cycle.
- pc increment wraps modulo 2^PC_W (255->0 at default).
- zflag is changed only by WRITE and cleared only by reset. NOP and jumps preserve it.
- Reset asserted mid-operation (including during WRITE): immediate return to IDLE, wr_en drops asynchronously, no done pulse, no partial pc update survives.
- Jump target equal to the current pc is legal (tight loop); no hazard logic is required.

Test Plan:
- Reset, then start=1 with ROM[0]=LDI r1,0x05 (0x8205), ROM[1]=HALT (0xF000) -> wr_en=1 with wr_addr=1, ctl=1, romx=0x05, alu_op=8, 5 cycles after first FETCH; done pulses once; busy falls; pc=1.
- ROM: ADD r3,r1,r2 (0x1650) -> in SELECT, ra_addr=1, rb_addr=2, ctl=0, alu_op=1; wr_en only in WRITE with wr_addr=3.
- JZ 0x10 after a WRITE with alu_zero=1 -> next rom_addr=0x10. Same with alu_zero=0 -> rom_addr=pc+1. Both take 2 cycles.
- JMP 0xFF, ROM[0xFF]=NOP -> pc wraps 0xFF->0x00 and fetch continues from 0.
- start pulsed while busy -> no effect on pc/state; after HALT, start restarts at pc=0.
- rst asserted during WRITE -> wr_en=0 immediately, all outputs 0, state IDLE, no done pulse.
